// File: rtl/snowbro2_pkg.sv
// Shared definitions for the snowbro2 68K program-ROM line cache.
package snowbro2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFillReq,
    StFillWait,
    StDone
  } prg_cache_st_t;

  localparam int unsigned PRG_LINES = 4;
  localparam int unsigned PRG_WORDS = 4;
  localparam int unsigned PRG_AW    = 19;

  localparam int unsigned PRG_IB   = $clog2(PRG_LINES);
  localparam int unsigned PRG_WB   = $clog2(PRG_WORDS);
  localparam int unsigned PRG_TAGW = PRG_AW - PRG_IB - PRG_WB;

endpackage

// File: rtl/snowbro2_prg_cache_mem.sv
// Data, tag and valid storage for the program-ROM line cache.
module snowbro2_prg_cache_mem #(
  parameter int unsigned LINES = 4,
  parameter int unsigned WORDS = 4,
  parameter int unsigned TAGW  = 15
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_all_i,
  input  logic                       alloc_i,
  input  logic [$clog2(LINES)-1:0]   alloc_idx_i,
  input  logic [TAGW-1:0]            alloc_tag_i,
  input  logic                       set_valid_i,
  input  logic                       wr_en_i,
  input  logic [$clog2(LINES)-1:0]   wr_idx_i,
  input  logic [$clog2(WORDS)-1:0]   wr_word_i,
  input  logic [15:0]                wr_data_i,
  input  logic [$clog2(LINES)-1:0]   rd_idx_i,
  input  logic [$clog2(WORDS)-1:0]   rd_word_i,
  output logic [15:0]                rd_data_o,
  output logic                       rd_valid_o,
  output logic [TAGW-1:0]            rd_tag_o
);

  logic [15:0]     data_q [LINES][WORDS];
  logic [TAGW-1:0] tag_q  [LINES];
  logic [LINES-1:0] valid_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) data_q[wr_idx_i][wr_word_i] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (alloc_i) tag_q[alloc_idx_i] <= alloc_tag_i;
  end

  // Allocation invalidates the line so a partial fill is never hit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (clr_all_i) begin
      valid_q <= '0;
    end else begin
      if (alloc_i)     valid_q[alloc_idx_i] <= 1'b0;
      if (set_valid_i) valid_q[wr_idx_i]    <= 1'b1;
    end
  end

  assign rd_data_o  = data_q[rd_idx_i][rd_word_i];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];

endmodule

// File: rtl/snowbro2_prg_cache.sv
// Direct-mapped read-only line cache between the 68K program port and the SDRAM ROM slot.
module snowbro2_prg_cache
  import snowbro2_pkg::*;
#(
  parameter int unsigned LINES = PRG_LINES,
  parameter int unsigned WORDS = PRG_WORDS,
  parameter int unsigned AW    = PRG_AW
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          FLUSH,
  input  logic          CPU_PRG_CS,
  input  logic [AW-1:0] CPU_PRG_ADDR,
  output logic [15:0]   CPU_PRG_DATA,
  output logic          CPU_PRG_OK,
  output logic          ROM68K_CS,
  output logic [AW-1:0] ROM68K_ADDR,
  input  logic          ROM68K_OK,
  input  logic [15:0]   ROM68K_DOUT
);

  localparam int unsigned IB   = $clog2(LINES);
  localparam int unsigned WB   = $clog2(WORDS);
  localparam int unsigned TAGW = AW - IB - WB;

  prg_cache_st_t st_q, st_d;
  logic [IB-1:0]   idx_q, idx_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [WB-1:0]   cnt_q, cnt_d, cnt_nxt;
  logic            ok_q, ok_d;
  logic [15:0]     data_q, data_d;
  logic [AW-1:0]   ok_addr_q, ok_addr_d;
  logic            rom_cs_q, rom_cs_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;

  logic [WB-1:0]   cpu_word;
  logic [IB-1:0]   cpu_idx;
  logic [TAGW-1:0] cpu_tag;

  logic            clr_all, alloc, set_valid, wr_en, hit;
  logic [15:0]     rd_data;
  logic            rd_valid;
  logic [TAGW-1:0] rd_tag;

  assign cpu_word = CPU_PRG_ADDR[WB-1:0];
  assign cpu_idx  = CPU_PRG_ADDR[WB+IB-1:WB];
  assign cpu_tag  = CPU_PRG_ADDR[AW-1:WB+IB];
  assign hit      = rd_valid && (rd_tag == cpu_tag);
  assign cnt_nxt  = cnt_q + WB'(1);

  snowbro2_prg_cache_mem #(
    .LINES (LINES),
    .WORDS (WORDS),
    .TAGW  (TAGW)
  ) u_mem (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .clr_all_i   (clr_all),
    .alloc_i     (alloc),
    .alloc_idx_i (cpu_idx),
    .alloc_tag_i (cpu_tag),
    .set_valid_i (set_valid),
    .wr_en_i     (wr_en),
    .wr_idx_i    (idx_q),
    .wr_word_i   (cnt_q),
    .wr_data_i   (ROM68K_DOUT),
    .rd_idx_i    (cpu_idx),
    .rd_word_i   (cpu_word),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag)
  );

  always_comb begin
    st_d       = st_q;
    idx_d      = idx_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    ok_d       = ok_q;
    data_d     = data_q;
    ok_addr_d  = ok_addr_q;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    clr_all    = 1'b0;
    alloc      = 1'b0;
    set_valid  = 1'b0;
    wr_en      = 1'b0;

    if (FLUSH) begin
      clr_all  = 1'b1;
      ok_d     = 1'b0;
      rom_cs_d = 1'b0;
      st_d     = StIdle;
    end else begin
      unique case (st_q)
        StIdle: begin
          if (ok_q) begin
            // OK is only valid for the address it was produced for.
            if (!CPU_PRG_CS || (CPU_PRG_ADDR != ok_addr_q)) ok_d = 1'b0;
          end else if (CPU_PRG_CS) begin
            if (hit) begin
              data_d    = rd_data;
              ok_d      = 1'b1;
              ok_addr_d = CPU_PRG_ADDR;
            end else begin
              idx_d      = cpu_idx;
              tag_d      = cpu_tag;
              cnt_d      = '0;
              alloc      = 1'b1;
              rom_cs_d   = 1'b1;
              rom_addr_d = {cpu_tag, cpu_idx, {WB{1'b0}}};
              st_d       = StFillReq;
            end
          end
        end
        // Guard cycle: the slot's OK may still belong to the previous address.
        StFillReq: st_d = StFillWait;
        StFillWait: begin
          if (ROM68K_OK) begin
            wr_en = 1'b1;
            if (&cnt_q) begin
              set_valid = 1'b1;
              rom_cs_d  = 1'b0;
              st_d      = StDone;
            end else begin
              cnt_d      = cnt_nxt;
              rom_addr_d = {tag_q, idx_q, cnt_nxt};
              st_d       = StFillReq;
            end
          end
        end
        StDone:  st_d = StIdle;
        default: st_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      st_q       <= StIdle;
      idx_q      <= '0;
      tag_q      <= '0;
      cnt_q      <= '0;
      ok_q       <= 1'b0;
      data_q     <= '0;
      ok_addr_q  <= '0;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      st_q       <= st_d;
      idx_q      <= idx_d;
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
      ok_q       <= ok_d;
      data_q     <= data_d;
      ok_addr_q  <= ok_addr_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  assign CPU_PRG_OK   = ok_q;
  assign CPU_PRG_DATA = data_q;
  assign ROM68K_CS    = rom_cs_q;
  assign ROM68K_ADDR  = rom_addr_q;

endmodule
